// File: rtl/dma_ctrl.sv
// DMA register bank and transfer sequencer: decodes peripheral-bus accesses,
// launches the read-side and write-side ports together and reports completion.
module dma_ctrl #(
  parameter logic [14:0] BASE_ADDR = 15'h0190
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        irq,
  output logic        rd_go,
  output logic [15:0] rd_start_addr,
  output logic        wr_go,
  output logic [15:0] wr_start_addr,
  output logic [15:0] transfer_len,
  output logic        port_int_clear,
  input  logic        rd_busy,
  input  logic        wr_busy,
  input  logic        rd_int,
  input  logic        wr_int,
  input  logic        rd_error,
  input  logic        wr_error
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic        ie_q, ie_d, done_q, done_d, irq_q, irq_d;
  logic        rd_err_q, rd_err_d, wr_err_q, wr_err_d, cfg_err_q, cfg_err_d;
  logic        rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;

  logic       sel, busy, ctl_wr, start_wr, clr_wr;
  logic [2:0] idx;

  // Port busy flags are observed for debug only and take no part in sequencing.
  logic unused_busy;
  assign unused_busy = rd_busy ^ wr_busy;

  assign sel      = per_en && (per_addr[13:3] == BASE_ADDR[14:4]);
  assign idx      = per_addr[2:0];
  assign busy     = (state_q == LAUNCH) || (state_q == RUN);
  assign ctl_wr   = sel && (idx == 3'd0) && per_we[0];
  assign start_wr = ctl_wr && per_din[0];
  assign clr_wr   = ctl_wr && per_din[2];

  assign rd_start_addr = src_q;
  assign wr_start_addr = dst_q;
  assign transfer_len  = len_q;
  assign irq           = irq_q;

  function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                             input logic [15:0] din,
                                             input logic [1:0]  we);
    byte_merge = old_v;
    if (we[0]) byte_merge[7:0]  = din[7:0];
    if (we[1]) byte_merge[15:8] = din[15:8];
  endfunction

  always_comb begin
    // NOTE: every signal written here is defaulted first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    len_d          = len_q;
    ie_d           = ie_q;
    done_d         = done_q;
    rd_err_d       = rd_err_q;
    wr_err_d       = wr_err_q;
    cfg_err_d      = cfg_err_q;
    rd_seen_d      = rd_seen_q;
    wr_seen_d      = wr_seen_q;
    rd_go          = 1'b0;
    wr_go          = 1'b0;
    port_int_clear = 1'b0;

    if (sel && !busy) begin
      unique case (idx)
        3'd1:    src_d = byte_merge(src_q, per_din, per_we);
        3'd2:    dst_d = byte_merge(dst_q, per_din, per_we);
        3'd3:    len_d = byte_merge(len_q, per_din, per_we);
        default: ;
      endcase
    end

    if (ctl_wr) ie_d = per_din[1];

    // Clear is applied before START is evaluated, so CLR|START restarts cleanly.
    if (clr_wr) begin
      done_d    = 1'b0;
      rd_err_d  = 1'b0;
      wr_err_d  = 1'b0;
      cfg_err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_wr) begin
          if (len_q == 16'd0 || len_q[0]) begin
            cfg_err_d = 1'b1;
          end else begin
            done_d    = 1'b0;
            rd_err_d  = 1'b0;
            wr_err_d  = 1'b0;
            cfg_err_d = 1'b0;
            state_d   = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        rd_go     = 1'b1;
        wr_go     = 1'b1;
        rd_seen_d = 1'b0;
        wr_seen_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        rd_seen_d = rd_seen_q | rd_int;
        wr_seen_d = wr_seen_q | wr_int;
        if (rd_error) rd_err_d = 1'b1;
        if (wr_error) wr_err_d = 1'b1;
        if (rd_seen_d && wr_seen_d) state_d = FINISH;
      end
      FINISH: begin
        port_int_clear = 1'b1;
        done_d         = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Built from next-state values so irq tracks DONE/IE with a single register delay.
    irq_d = done_d & ie_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      ie_q      <= ie_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      rd_err_q  <= rd_err_d;
      wr_err_q  <= wr_err_d;
      cfg_err_q <= cfg_err_d;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
    end
  end

  always_comb begin
    per_dout = '0;
    if (sel && per_we == 2'b00) begin
      unique case (idx)
        3'd0:    per_dout = {14'd0, ie_q, 1'b0};
        3'd1:    per_dout = src_q;
        3'd2:    per_dout = dst_q;
        3'd3:    per_dout = len_q;
        3'd4:    per_dout = {11'd0, cfg_err_q, wr_err_q, rd_err_q, done_q, busy};
        default: per_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboarded random bench for dma_ctrl: stimulus tasks update a transaction-level
// model and queue expectations; a negedge monitor pops them as the DUT responds.
`timescale 1ns/1ps
module tb_dma_ctrl;

  localparam logic [13:0] WBASE = 14'h00C8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [15:0] per_dout;
  logic        irq, rd_go, wr_go, port_int_clear;
  logic [15:0] rd_start_addr, wr_start_addr, transfer_len;
  logic        rd_busy = 1'b0, wr_busy = 1'b0;
  logic        rd_int = 1'b0, wr_int = 1'b0, rd_error = 1'b0, wr_error = 1'b0;

  dma_ctrl dut (
    .clk(clk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .irq(irq),
    .rd_go(rd_go), .rd_start_addr(rd_start_addr), .wr_go(wr_go),
    .wr_start_addr(wr_start_addr), .transfer_len(transfer_len),
    .port_int_clear(port_int_clear), .rd_busy(rd_busy), .wr_busy(wr_busy),
    .rd_int(rd_int), .wr_int(wr_int), .rd_error(rd_error), .wr_error(wr_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
  } go_t;

  typedef struct packed {
    logic [15:0] data;
    logic        irq;
  } rd_t;

  go_t  go_q[$];
  int   fin_q[$];
  rd_t  rd_q[$];

  // Transaction-level model of the programmer-visible state.
  logic [15:0] m_src = '0, m_dst = '0, m_len = '0;
  logic        m_ie = 0, m_done = 0, m_rd_err = 0, m_wr_err = 0, m_cfg_err = 0, m_busy = 0;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_reg(input int idx);
    case (idx)
      0:       return m_ie ? 16'h0002 : 16'h0000;
      1:       return m_src;
      2:       return m_dst;
      3:       return m_len;
      4:       return {11'd0, m_cfg_err, m_wr_err, m_rd_err, m_done, m_busy};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                        input logic [1:0] we);
    logic [15:0] r;
    r = o;
    if (we[0]) r[7:0]  = d[7:0];
    if (we[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic model_clear();
    m_done = 0; m_rd_err = 0; m_wr_err = 0; m_cfg_err = 0;
  endtask

  task automatic model_write(input int idx, input logic [15:0] d, input logic [1:0] we,
                             input int n);
    go_t g;
    if (idx >= 1 && idx <= 3 && !m_busy) begin
      if (idx == 1) m_src = merge(m_src, d, we);
      if (idx == 2) m_dst = merge(m_dst, d, we);
      if (idx == 3) m_len = merge(m_len, d, we);
    end
    if (idx == 0 && we[0]) begin
      m_ie = d[1];
      if (d[2]) model_clear();
      if (d[0] && !m_busy) begin
        if (m_len == 0 || m_len % 2 == 1) begin
          m_cfg_err = 1;
        end else begin
          model_clear();
          m_busy = 1;
          g.cyc = 32'(n + 1); g.src = m_src; g.dst = m_dst; g.len = m_len;
          go_q.push_back(g);
        end
      end
    end
  endtask

  task automatic bus_write(input int idx, input logic [15:0] d, input logic [1:0] we);
    @(posedge clk); #1;
    per_en = 1; per_we = we; per_addr = WBASE + 14'(idx); per_din = d;
    model_write(idx, d, we, cyc);
    @(posedge clk); #1;
    per_en = 0; per_we = 2'b00; per_din = '0;
  endtask

  task automatic bus_read(input int idx);
    rd_t r;
    @(posedge clk); #1;
    per_en = 1; per_we = 2'b00; per_addr = WBASE + 14'(idx);
    r.data = (idx < 8) ? m_reg(idx) : 16'h0000;
    r.irq  = m_done & m_ie;
    rd_q.push_back(r);
    @(posedge clk); #1;
    per_en = 0;
  endtask

  // Acts as both ports: optional error pulse, then completion flags after the given delays.
  task automatic run_xfer(input int rd_d, input int wr_d, input logic rd_e, input logic wr_e);
    int mx;
    logic got;
    if (rd_e || wr_e) begin
      @(posedge clk); #1;
      rd_error = rd_e; wr_error = wr_e;
      if (rd_e) m_rd_err = 1;
      if (wr_e) m_wr_err = 1;
      @(posedge clk); #1;
      rd_error = 0; wr_error = 0;
    end
    mx = (rd_d > wr_d) ? rd_d : wr_d;
    for (int k = 0; k <= mx; k++) begin
      @(posedge clk); #1;
      if (k >= rd_d) rd_int = 1;
      if (k >= wr_d) wr_int = 1;
    end
    fin_q.push_back(cyc + 1);
    got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      got = port_int_clear;
    end
    check("finish_seen", 32'(got), 1);
    @(posedge clk); #1;
    rd_int = 0; wr_int = 0;
    m_busy = 0; m_done = 1;
  endtask

  always @(negedge clk) begin : monitor
    go_t g;
    rd_t r;
    int  fc;
    if (reset_n) begin
      if (rd_go || wr_go) begin
        check("go_pair", {30'd0, rd_go, wr_go}, 32'd3);
        check("go_queued", 32'(go_q.size() != 0), 1);
        if (go_q.size() != 0) begin
          g = go_q.pop_front();
          check("go_cycle", 32'(cyc), g.cyc);
          check("rd_start_addr", {16'd0, rd_start_addr}, {16'd0, g.src});
          check("wr_start_addr", {16'd0, wr_start_addr}, {16'd0, g.dst});
          check("transfer_len", {16'd0, transfer_len}, {16'd0, g.len});
        end
      end
      if (port_int_clear) begin
        check("finish_queued", 32'(fin_q.size() != 0), 1);
        if (fin_q.size() != 0) begin
          fc = fin_q.pop_front();
          check("finish_cycle", 32'(cyc), 32'(fc));
        end
      end
      if (per_en && per_we == 2'b00) begin
        check("read_queued", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          check("read_data", {16'd0, per_dout}, {16'd0, r.data});
          check("read_irq", {31'd0, irq}, {31'd0, r.irq});
        end
      end
      if (per_en && per_we != 2'b00) check("dout_on_write", {16'd0, per_dout}, 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] src, dst, len, ctl;
    logic [31:0] r;
    int rd_d, wr_d;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_go", {31'd0, rd_go}, 0);
    check("reset_wr_go", {31'd0, wr_go}, 0);
    check("reset_irq", {31'd0, irq}, 0);
    check("reset_clear", {31'd0, port_int_clear}, 0);
    reset_n = 1;

    for (int i = 0; i < 9; i++) bus_read(i);

    // Basic transfer with IE, wr_int five cycles after rd_int.
    bus_write(1, 16'h0200, 2'b11);
    bus_write(2, 16'h0300, 2'b11);
    bus_write(3, 16'h0008, 2'b11);
    bus_write(0, 16'h0003, 2'b01);
    bus_read(4);
    run_xfer(0, 5, 0, 0);
    bus_read(4);
    bus_write(0, 16'h0006, 2'b01);
    bus_read(4);
    bus_read(0);

    // Bad lengths raise CFG_ERR without launching.
    bus_write(3, 16'h0007, 2'b11);
    bus_write(0, 16'h0001, 2'b01);
    repeat (3) @(posedge clk);
    bus_read(4);
    bus_write(3, 16'h0000, 2'b11);
    bus_write(0, 16'h0001, 2'b01);
    repeat (3) @(posedge clk);
    bus_read(4);

    // Writes and START while busy are ignored; rd_error is sticky.
    bus_write(3, 16'h0008, 2'b11);
    bus_write(0, 16'h0001, 2'b01);
    bus_write(1, 16'hFFFF, 2'b11);
    bus_write(0, 16'h0001, 2'b01);
    bus_read(1);
    run_xfer(1, 3, 1, 0);
    bus_read(4);
    bus_read(1);

    // IE set while DONE is already high.
    bus_write(0, 16'h0002, 2'b01);
    @(negedge clk);
    check("irq_after_ie", {31'd0, irq}, {31'd0, m_done & m_ie});

    // Simultaneous completion flags.
    bus_write(0, 16'h0007, 2'b01);
    run_xfer(2, 2, 0, 1);
    bus_read(4);

    // Byte-lane writes and an out-of-window access.
    bus_write(3, 16'h0000, 2'b11);
    bus_write(3, 16'h12AB, 2'b01);
    bus_read(3);
    bus_write(3, 16'h34CD, 2'b10);
    bus_read(3);
    bus_write(9, 16'hBEEF, 2'b11);
    bus_read(9);
    bus_write(0, 16'h0004, 2'b01);

    // Randomised transfers.
    for (int t = 0; t < 16; t++) begin
      src = 16'($urandom);
      dst = 16'($urandom);
      r = $urandom;
      if (t % 5 == 4) len = (r[0]) ? 16'h0000 : (r[15:0] | 16'h0001);
      else            len = 16'($urandom_range(1, 16'h7FFF)) << 1;
      bus_write(1, src, 2'b11);
      bus_write(2, dst, 2'($urandom_range(1, 3)));
      bus_write(3, len, 2'b11);
      ctl = {13'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      bus_write(0, ctl, 2'b01);
      if (m_busy) begin
        if (t % 3 == 0) bus_read(4);
        rd_d = $urandom_range(0, 5);
        wr_d = $urandom_range(0, 5);
        run_xfer(rd_d, wr_d, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end
      bus_read(4);
      bus_read(0);
      bus_read(2);
      if (t % 4 == 3) bus_write(0, 16'h0004, 2'b01);
    end

    // Reset in the middle of a transfer.
    bus_write(3, 16'h0010, 2'b11);
    bus_write(0, 16'h0003, 2'b01);
    @(posedge clk); #1;
    reset_n = 0;
    #2;
    check("rst_rd_go", {31'd0, rd_go}, 0);
    check("rst_wr_go", {31'd0, wr_go}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_clear", {31'd0, port_int_clear}, 0);
    m_src = '0; m_dst = '0; m_len = '0; m_ie = 0; m_busy = 0;
    model_clear();
    @(posedge clk); #1;
    reset_n = 1;
    bus_read(4);
    bus_read(1);
    bus_read(3);
    repeat (6) @(posedge clk);
    check("go_no_pulse_after_reset", 32'(go_q.size()), 0);

    repeat (4) @(posedge clk);
    check("fin_leftover", 32'(fin_q.size()), 0);
    check("read_leftover", 32'(rd_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Register bank and transfer sequencer for the DMA peripheral, sitting directly upstream of the two dma_port channel instances.
- Decodes openMSP430 peripheral-bus accesses and holds the source, destination and length configuration.
- Launches the read-side port (memory→FIFO) and the write-side port (FIFO→memory) together, collects both completions, and raises a single interrupt with sticky error status.

Parameters:
- BASE_ADDR, 15'h0190: byte base address of the register window; 16 bytes (8 words) decoded.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral access strobe
- per_we  in  2  byte write enables (bit0 low byte, bit1 high byte); 00 = read
- per_dout  out  16  read data; 0 when not selected
- irq  out  1  DMA interrupt request
- rd_go  out  1  one-cycle start pulse to read-side port
- rd_start_addr  out  16  source byte address (SRC register)
- wr_go  out  1  one-cycle start pulse to write-side port
- wr_start_addr  out  16  destination byte address (DST register)
- transfer_len  out  16  byte count (LEN register), shared by both ports
- port_int_clear  out  1  one-cycle pulse clearing both ports' int_gen
- rd_busy, wr_busy  in  1  port busy flags
- rd_int, wr_int  in  1  port completion flags (level, held until cleared)
- rd_error, wr_error  in  1  port error_generated (level, valid only during a transfer)

Behaviour:
- Select: per_en & (per_addr[13:3] == BASE_ADDR[14:4]); register index = per_addr[2:0].
- Registers:
  - idx0 CTL (bit0 START, write-1 pulse, reads 0; bit1 IE; bit2 CLR, write-1 pulse, reads 0).
  - idx1 SRC, idx2 DST, idx3 LEN.
  - idx4 STAT, read-only: bit0 BUSY, bit1 DONE, bit2 RD_ERR, bit3 WR_ERR, bit4 CFG_ERR.
  - Other indices read 0 and ignore writes.
- Writes:
  - Byte-granular for SRC/DST/LEN.
  - CTL responds only when per_we[0]=1.
  - SRC/DST/LEN writes while BUSY=1 are ignored.
- Reads: per_dout is combinational, equal to the selected register when per_we==0, else 0.
- Reset values: all registers, flags and outputs 0; FSM in IDLE.
- FSM states:
  - IDLE: on a START write:
    - If LEN==0 or LEN[0]==1: set CFG_ERR, stay in IDLE.
    - Otherwise: clear DONE, RD_ERR, WR_ERR and CFG_ERR; go to LAUNCH.
  - LAUNCH (1 cycle): rd_go=1, wr_go=1, BUSY=1; clear internal rd_seen/wr_seen; go to RUN.
  - RUN:
    - Each cycle: rd_int sets rd_seen, wr_int sets wr_seen; rd_error sets RD_ERR, wr_error sets WR_ERR (sticky).
    - When rd_seen & wr_seen, including both set in the same cycle: go to FINISH.
  - FINISH (1 cycle): port_int_clear=1, BUSY=0, DONE=1; go to IDLE.
- Latency: START write in cycle N → rd_go/wr_go high in cycle N+1. DONE is visible the cycle after FINISH.
- irq = DONE & IE, registered. Setting IE while DONE=1 raises irq on the next cycle.
- CLR write clears DONE, RD_ERR, WR_ERR and CFG_ERR. BUSY and the FSM are unaffected.
- CLR and START in the same write: clear is applied first, then START is evaluated.
- START while BUSY=1 is ignored: no pulse, no flag change.
- rd_busy/wr_busy are not used for sequencing; they are for debug only.
- Async reset mid-transfer returns to IDLE with all outputs 0. The ports are reset by the same reset_n.

Test Plan:
- Reset, then read idx0..idx7 → all 0x0000; irq=0, rd_go=wr_go=0.
- Write SRC=0x0200, DST=0x0300, LEN=0x0008, CTL=0x0003 → one-cycle rd_go/wr_go pulse one cycle after the CTL write; STAT=0x0001. Assert rd_int, then wr_int 5 cycles later → port_int_clear pulse; STAT=0x0002; irq=1. Write CTL=0x0006 → STAT=0, irq=0 with IE kept.
- LEN=0x0007, START → no go pulses; STAT=0x0010. LEN=0, START → same result.
- During RUN: pulse rd_error 1 cycle, write SRC=0xFFFF, write START → SRC still 0x0200, no extra go pulse. Completion → STAT=0x0006.
- rd_int and wr_int rise in the same cycle → FINISH the following cycle; DONE set exactly once.
- Byte write per_we=01 of 0x12AB to LEN=0x0000 → LEN=0x00AB. Drive reset_n low during RUN → STAT=0, FSM in IDLE, rd_go=wr_go=0.
